// File: rtl/cpu_defs.sv
// Shared definitions for the memory port arbiter: FSM state encoding and port indices.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic PORT_IF  = 1'b0;  // instruction fetch requester
    localparam logic PORT_MEM = 1'b1;  // data load/store requester

endpackage

// File: rtl/mux_21.sv
// Generic 2:1 mux.
// Ports: i_sel selects i_d1 when high, i_d0 when low; o_y is the selected input.
module mux_21 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-ported memory between instruction fetch
// (port 0) and data load/store (port 1). The winner is held for one complete
// memory transaction, then a turnaround cycle carries the ack pulse.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req*/we*/addr*/wdata*           requester inputs, held until ack
//   ack0/ack1                       registered one-cycle completion pulses
//   rdata                           registered read data, valid in the ack cycle
//   sel                             registered grant, drives the request muxes
//   mem_req/mem_we/mem_addr/mem_wdata  memory request side (combinational)
//   mem_ack/mem_rdata               memory completion and read data
module mem_port_arbiter
    import cpu_defs::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter bit          RR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          sel,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    state_e        r_state;
    logic          r_sel;
    logic          r_last;
    logic          r_ack0;
    logic          r_ack1;
    logic [DW-1:0] r_rdata;

    state_e        w_state_nxt;
    logic          w_sel_nxt;
    logic          w_last_nxt;
    logic          w_ack0_nxt;
    logic          w_ack1_nxt;
    logic [DW-1:0] w_rdata_nxt;
    logic          w_mem_req;
    logic          w_tie_grant;

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= PORT_IF;
            r_last  <= PORT_MEM;  // port 0 wins the first tie
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_ack0  <= w_ack0_nxt;
            r_ack1  <= w_ack1_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    // Arbitration, transaction tracking and ack generation.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        w_rdata_nxt = r_rdata;
        w_mem_req   = 1'b0;
        w_tie_grant = RR ? ~r_last : PORT_MEM;

        unique case (r_state)
            IDLE: begin
                if (req0 && req1) begin
                    w_sel_nxt   = w_tie_grant;
                    w_last_nxt  = w_tie_grant;
                    w_state_nxt = BUSY;
                end else if (req0) begin
                    w_sel_nxt   = PORT_IF;
                    w_state_nxt = BUSY;
                end else if (req1) begin
                    w_sel_nxt   = PORT_MEM;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // Requester inputs are not looked at here, so an early req drop
                // cannot cut the transaction short.
                w_mem_req = 1'b1;
                if (mem_ack) begin
                    w_rdata_nxt = mem_rdata;
                    w_ack0_nxt  = (r_sel == PORT_IF);
                    w_ack1_nxt  = (r_sel == PORT_MEM);
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request muxes follow the registered grant.
    mux_21 #(.WIDTH(AW)) u_addr_mux (
        .i_sel (r_sel),
        .i_d0  (addr0),
        .i_d1  (addr1),
        .o_y   (mem_addr)
    );

    mux_21 #(.WIDTH(DW)) u_wdata_mux (
        .i_sel (r_sel),
        .i_d0  (wdata0),
        .i_d1  (wdata1),
        .o_y   (mem_wdata)
    );

    mux_21 #(.WIDTH(1)) u_we_mux (
        .i_sel (r_sel),
        .i_d0  (we0),
        .i_d1  (we1),
        .o_y   (mem_we)
    );

    assign mem_req = w_mem_req;
    assign ack0    = r_ack0;
    assign ack1    = r_ack1;
    assign rdata   = r_rdata;
    assign sel     = r_sel;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance carries most
// scenarios, a fixed-priority instance carries the priority scenario.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    // Round-robin instance
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, sel, mem_req, mem_we, mem_ack;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    // Fixed-priority instance
    logic        f_req0, f_we0, f_req1, f_we1;
    logic [31:0] f_addr0, f_wdata0, f_addr1, f_wdata1;
    logic        f_ack0, f_ack1, f_sel, f_mem_req, f_mem_we, f_mem_ack;
    logic [31:0] f_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;

    int vec  = 0;
    int errs = 0;
    int lat   = 1;
    int f_lat = 1;
    int cnt   = 0;
    int f_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .RR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .sel(sel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RR(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0),
        .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1),
        .ack0(f_ack0), .ack1(f_ack1), .rdata(f_rdata), .sel(f_sel),
        .mem_req(f_mem_req), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_ack(f_mem_ack), .mem_rdata(f_mem_rdata)
    );

    // Memory models: ack in the lat-th consecutive cycle of mem_req.
    always @(posedge clk) begin
        #2;
        if (mem_req !== 1'b1) begin cnt = 0; mem_ack = 1'b0; end
        else begin cnt++; mem_ack = (cnt >= lat); end
    end

    always @(posedge clk) begin
        #2;
        if (f_mem_req !== 1'b1) begin f_cnt = 0; f_mem_ack = 1'b0; end
        else begin f_cnt++; f_mem_ack = (f_cnt >= f_lat); end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        f_req0 = 0; f_req1 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0 = 1; req1 = 1; lat = 1;
        repeat (3) begin
            @(negedge clk);
            vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_mem_req: got %b expected 0", mem_req); end
            vec++; if ({ack1, ack0} !== 2'b00) begin errs++; $display("FAIL rst_ack: got %b expected 00", {ack1, ack0}); end
            vec++; if (rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h expected 0", rdata); end
            vec++; if (sel !== 1'b0) begin errs++; $display("FAIL rst_sel: got %b expected 0", sel); end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);  // IDLE, both requests pending
        @(negedge clk);  // first BUSY cycle after a tie
        vec++; if (sel !== 1'b0) begin errs++; $display("FAIL rst_first_grant: got %b expected 0", sel); end
        vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rst_first_busy: got %b expected 1", mem_req); end
        @(negedge clk);  // DONE
        vec++; if ({ack1, ack0} !== 2'b01) begin errs++; $display("FAIL rst_first_ack: got %b expected 01", {ack1, ack0}); end
        req0 = 0; req1 = 0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        req0 = 1; we0 = 0; addr0 = 32'h100; lat = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);  // IDLE, request sampled at the next edge
        vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL sr_idle_req: got %b expected 0", mem_req); end
        @(negedge clk);  // BUSY
        vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL sr_mem_req: got %b expected 1", mem_req); end
        vec++; if (mem_addr !== 32'h100) begin errs++; $display("FAIL sr_mem_addr: got %h expected 100", mem_addr); end
        vec++; if (mem_we !== 1'b0) begin errs++; $display("FAIL sr_mem_we: got %b expected 0", mem_we); end
        vec++; if (ack0 !== 1'b0) begin errs++; $display("FAIL sr_early_ack: got %b expected 0", ack0); end
        @(negedge clk);  // DONE
        vec++; if ({ack1, ack0} !== 2'b01) begin errs++; $display("FAIL sr_ack: got %b expected 01", {ack1, ack0}); end
        vec++; if (rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL sr_rdata: got %h expected deadbeef", rdata); end
        vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL sr_done_req: got %b expected 0", mem_req); end
        req0 = 0; mem_rdata = 32'h12345678;
        @(negedge clk);  // IDLE
        vec++; if (ack0 !== 1'b0) begin errs++; $display("FAIL sr_ack_clear: got %b expected 0", ack0); end
        vec++; if (rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL sr_rdata_hold: got %h expected deadbeef", rdata); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int last_c = -1;
        @(posedge clk); #1;
        req0 = 1; addr0 = 32'h200; lat = 1; mem_rdata = 32'hA0A0A0A0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            if (ack0 === 1'b1) begin
                vec++; if (rdata !== (n == 0 ? 32'hA0A0A0A0 : 32'hB1B1B1B1)) begin errs++; $display("FAIL b2b_rdata%0d: got %h", n, rdata); end
                if (n > 0) begin
                    vec++; if (c - last_c !== 3) begin errs++; $display("FAIL b2b_spacing: got %0d expected 3", c - last_c); end
                end
                last_c = c; n++;
                mem_rdata = 32'hB1B1B1B1;
            end
        end
        req0 = 0;
        vec++; if (n !== 2) begin errs++; $display("FAIL b2b_count: got %0d expected 2", n); end
        @(negedge clk);
    endtask

    task automatic test_pending();
        @(posedge clk); #1;
        req0 = 1; addr0 = 32'h10; lat = 1;
        @(negedge clk);  // IDLE
        @(negedge clk);  // BUSY for port 0; port 1 arrives now
        req1 = 1; we1 = 0; addr1 = 32'h30;
        @(negedge clk);  // DONE
        vec++; if ({ack1, ack0} !== 2'b01) begin errs++; $display("FAIL pend_ack0: got %b expected 01", {ack1, ack0}); end
        req0 = 0;
        @(negedge clk);  // IDLE
        @(negedge clk);  // BUSY for port 1
        vec++; if (sel !== 1'b1) begin errs++; $display("FAIL pend_sel: got %b expected 1", sel); end
        vec++; if (mem_addr !== 32'h30) begin errs++; $display("FAIL pend_addr: got %h expected 30", mem_addr); end
        @(negedge clk);  // DONE
        vec++; if ({ack1, ack0} !== 2'b10) begin errs++; $display("FAIL pend_ack1: got %b expected 10", {ack1, ack0}); end
        req1 = 0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        int n = 0;
        int last_c = -1;
        bit prev = 0;
        logic exp_p;
        apply_reset();
        lat = 2; req0 = 1; req1 = 1; addr0 = 32'h0; addr1 = 32'h4;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if ((ack0 | ack1) === 1'b1) begin
                exp_p = n[0];
                vec++; if ({ack1, ack0} !== (exp_p ? 2'b10 : 2'b01)) begin errs++; $display("FAIL rr_ack%0d: got %b", n, {ack1, ack0}); end
                vec++; if (sel !== exp_p) begin errs++; $display("FAIL rr_sel%0d: got %b expected %b", n, sel, exp_p); end
                vec++; if (prev) begin errs++; $display("FAIL rr_ack_width%0d: got 2+ cycles expected 1", n); end
                if (n > 0) begin
                    vec++; if (c - last_c !== 4) begin errs++; $display("FAIL rr_spacing%0d: got %0d expected 4", n, c - last_c); end
                end
                last_c = c; n++;
            end
            prev = ((ack0 | ack1) === 1'b1);
        end
        req0 = 0; req1 = 0;
        vec++; if (n !== 4) begin errs++; $display("FAIL rr_count: got %0d expected 4", n); end
        @(negedge clk);
        vec++; if ({ack1, ack0} !== 2'b00) begin errs++; $display("FAIL rr_last_width: got %b expected 00", {ack1, ack0}); end
    endtask

    task automatic test_fixed_priority();
        int n = 0;
        int last_c = -1;
        bit saw0 = 0;
        bit got0 = 0;
        @(posedge clk); #1;
        f_lat = 2; f_req0 = 1; f_req1 = 1; f_we0 = 0; f_we1 = 0;
        f_addr0 = 32'h8; f_addr1 = 32'hC; f_wdata0 = 0; f_wdata1 = 0; f_mem_rdata = 32'h77;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (f_ack0 === 1'b1) saw0 = 1;
            if (f_ack1 === 1'b1) begin
                vec++; if (f_sel !== 1'b1) begin errs++; $display("FAIL fp_sel%0d: got %b expected 1", n, f_sel); end
                last_c = c; n++;
            end
        end
        vec++; if (n !== 3) begin errs++; $display("FAIL fp_count: got %0d expected 3", n); end
        vec++; if (saw0) begin errs++; $display("FAIL fp_port0_starve: got ack0 expected none"); end
        f_req1 = 0;
        for (int c = last_c + 1; c < last_c + 10 && !got0; c++) begin
            @(negedge clk);
            if (f_ack0 === 1'b1) begin
                got0 = 1;
                vec++; if (c - last_c !== 4) begin errs++; $display("FAIL fp_port0_delay: got %0d expected 4", c - last_c); end
                vec++; if (f_sel !== 1'b0) begin errs++; $display("FAIL fp_port0_sel: got %b expected 0", f_sel); end
            end
        end
        f_req0 = 0;
        vec++; if (!got0) begin errs++; $display("FAIL fp_port0_ack: got none expected ack0"); end
    endtask

    task automatic test_write_stall();
        int hi = 0;
        bit got = 0;
        @(posedge clk); #1;
        req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h55; lat = 5;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                hi++;
                vec++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h20, 32'h55}) begin
                    errs++; $display("FAIL ws_bus%0d: got we=%b addr=%h wdata=%h expected 1/20/55", hi, mem_we, mem_addr, mem_wdata);
                end
            end
            if ((ack0 | ack1) === 1'b1) begin
                got = 1;
                vec++; if ({ack1, ack0} !== 2'b10) begin errs++; $display("FAIL ws_ack: got %b expected 10", {ack1, ack0}); end
            end
        end
        req1 = 0; we1 = 0;
        vec++; if (hi !== 5) begin errs++; $display("FAIL ws_req_cycles: got %0d expected 5", hi); end
        vec++; if (!got) begin errs++; $display("FAIL ws_no_ack: got none expected ack1"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1;
        req0 = 1; we0 = 0; addr0 = 32'h44; lat = 10;
        @(negedge clk);  // IDLE
        @(negedge clk);  // 1st BUSY
        vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rmb_busy1: got %b expected 1", mem_req); end
        @(posedge clk); #3;  // inside 2nd BUSY
        vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rmb_busy2: got %b expected 1", mem_req); end
        rst_n = 1'b0;
        #1;
        vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rmb_async_drop: got %b expected 0", mem_req); end
        req0 = 0;
        repeat (2) begin
            @(negedge clk);
            vec++; if ({ack1, ack0, mem_req} !== 3'b000) begin errs++; $display("FAIL rmb_in_reset: got %b expected 000", {ack1, ack0, mem_req}); end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        vec++; if ({ack1, ack0, mem_req} !== 3'b000) begin errs++; $display("FAIL rmb_idle: got %b expected 000", {ack1, ack0, mem_req}); end
        @(posedge clk); #1;
        req0 = 1; lat = 1; mem_rdata = 32'hCAFE0001;
        @(negedge clk);  // IDLE
        @(negedge clk);  // BUSY
        @(negedge clk);  // DONE
        vec++; if ({ack1, ack0} !== 2'b01) begin errs++; $display("FAIL rmb_restart_ack: got %b expected 01", {ack1, ack0}); end
        vec++; if (rdata !== 32'hCAFE0001) begin errs++; $display("FAIL rmb_restart_rdata: got %h expected cafe0001", rdata); end
        req0 = 0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        mem_rdata = 0;
        f_req0 = 0; f_we0 = 0; f_addr0 = 0; f_wdata0 = 0;
        f_req1 = 0; f_we1 = 0; f_addr1 = 0; f_wdata1 = 0;
        f_mem_rdata = 0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_pending();
        test_contention();
        test_fixed_priority();
        test_write_stall();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between two requesters: port 0 is instruction fetch, port 1 is data load/store.
- Picks a winner by round-robin or fixed priority and holds it for one complete memory transaction.
- Drives the select of the address/write-data muxes and returns read data and a one-cycle ack to the winner.
- Sits between the CPU pipeline front end / MEM stage and the unified memory interface.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RR, 1: 1 = round-robin; 0 = fixed priority, port 1 always wins a tie.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0 write enable.
- addr0  input  AW  port 0 address.
- wdata0  input  DW  port 0 write data.
- req1  input  1  port 1 request; held high until ack1.
- we1  input  1  port 1 write enable.
- addr1  input  AW  port 1 address.
- wdata1  input  DW  port 1 write data.
- ack0  output  1  one-cycle completion pulse for port 0.
- ack1  output  1  one-cycle completion pulse for port 1.
- rdata  output  DW  registered read data; valid in the ack cycle; shared by both ports.
- sel  output  1  current grant, 0 = port 0, 1 = port 1; also drives the mux selects.
- mem_req  output  1  memory transaction request.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_ack  input  1  memory completion; sampled only while mem_req = 1.
- mem_rdata  input  DW  memory read data; valid when mem_ack = 1.

Behaviour:
- Reset: async on rst_n low. state = IDLE; sel = 0; ack0 = ack1 = 0; rdata = 0; mem_req = 0; last = 1, so port 0 wins the first tie.
- mem_addr, mem_wdata and mem_we are combinational muxes of the port inputs selected by sel. They are don't-care while mem_req = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: stay in IDLE; mem_req = 0.
- IDLE, one request: grant that port (sel <= that index) and go to BUSY.
- IDLE, both requests:
  - RR = 1: grant the port other than last.
  - RR = 0: grant port 1.
  - Either way, set last <= granted index and go to BUSY.
- BUSY: mem_req = 1 combinationally.
  - sel is frozen for the whole transaction.
  - Requester inputs must stay stable; an early req drop is a protocol error and is ignored (the transaction completes).
  - On an edge with mem_ack = 1: rdata <= mem_rdata, ack[sel] <= 1, go to DONE.
  - Otherwise stay in BUSY. There is no timeout.
- DONE: one turnaround cycle.
  - ack pulse is high this cycle, then cleared at the next edge.
  - mem_req = 0; no arbitration.
  - Next state is IDLE.
  - The requester samples ack and may deassert req or present a new request; both are seen in IDLE.
- Latency: req high before edge k with IDLE and mem_ack in the first BUSY cycle gives ack high in cycle k+2. A back-to-back same-port request costs 3 cycles per transaction.
- Fairness: with both req held and RR = 1, grants alternate 0,1,0,1.
- A request arriving during BUSY or DONE waits for IDLE and is not lost.
- rdata holds its value after ack until the next completion. Writes also load rdata with mem_rdata (don't-care).
- Reset mid-BUSY aborts the transaction immediately: mem_req falls asynchronously and no ack is issued.

Decomposition:
- Shared package (cpu_defs): state encoding IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2; constants PORT_IF = 1'b0 and PORT_MEM = 1'b1.
- Sub-module: the existing mux_21, instantiated with WIDTH = AW for the address, WIDTH = DW for write data, and WIDTH = 1 for we. The FSM and arbitration live in this block.

Test Plan:
- Reset: rst_n low for 3 cycles with req0 = req1 = 1 -> mem_req = 0, ack0 = ack1 = 0, rdata = 0, sel = 0. After release, the first grant goes to port 0.
- Single read: req0 with addr0 = 0x100, mem_ack in the first BUSY cycle with mem_rdata = 0xDEADBEEF -> mem_addr = 0x100, mem_we = 0, ack0 high exactly 2 cycles after req, rdata = 0xDEADBEEF.
- Contention, RR = 1: req0 and req1 held for 4 transactions, mem_ack after 2 BUSY cycles -> sel sequence 0,1,0,1; each ack lasts 1 cycle; acks are 4 cycles apart.
- Fixed priority, RR = 0: same stimulus -> every grant is port 1; port 0 waits until req1 drops.
- Write with stall: req1, we1 = 1, addr1 = 0x20, wdata1 = 0x55, mem_ack delayed 5 cycles -> mem_req stays high 5 cycles with stable mem_addr = 0x20, mem_wdata = 0x55, mem_we = 1; ack1 follows.
- Reset mid-BUSY: assert rst_n low during the 2nd BUSY cycle -> mem_req drops asynchronously; no ack; the FSM restarts in IDLE.
